load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the byte-addressed, little-endian data memory. Accepts byte, halfword and word load/store requests from the pipeline and enforces alignment and range checks. Drives the memory's registered read / full-word write port, using read-modify-write for sub-word stores, and returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- MEM_BYTES, 1024: memory size in bytes. Valid aligned word addresses are 0 .. MEM_BYTES-4.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_signed  in  1  sign-extend load data; ignored for word loads and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; 1 = misaligned, reserved size or out of range
- resp_rdata  out  32  load result; 0 for stores and errors
- mem_address  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_dataIn  out  32  full word to write
- mem_readEnable  out  1  memory read strobe
- mem_writeEnable  out  1  memory write strobe
- mem_memOut  in  32  memory read data, valid in the cycle after a readEnable cycle

## Operation
- States:
  - IDLE
  - RD: mem_readEnable=1
  - CAP: sample mem_memOut
  - WR: mem_writeEnable=1
- All outputs are registered.
- At most one of mem_readEnable / mem_writeEnable is high in any cycle.
- Request fields are latched on acceptance. req_valid while req_ready=0 is ignored.
- Error check at acceptance. Any of these gives an error:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - aligned address > MEM_BYTES-4
- On error: no memory access; the next cycle has resp_valid=1, resp_err=1, resp_rdata=0; state stays IDLE.
- Load path: IDLE → RD → CAP → IDLE.
  - Byte lane k = addr[1:0]; half lane = addr[1].
  - Selected byte/half is extended: sign if req_signed, else zero.
  - resp_rdata is registered at the end of CAP.
- Word store: IDLE → WR → IDLE, with mem_dataIn = req_wdata.
- Byte/half store: IDLE → RD → CAP → WR → IDLE.
  - In CAP, the merge register is loaded with mem_memOut, replacing only the addressed lane(s) with the low bits of req_wdata.
  - WR writes the merged word.
- resp_valid is asserted in the cycle after the final state (RD→CAP for loads; WR for stores), with the FSM already back in IDLE and req_ready=1. A new request may be accepted in that same cycle.
- mem_address and mem_dataIn hold their last values when idle.
- Reset values:
  - state IDLE, req_ready=1
  - resp_valid=0, resp_err=0, resp_rdata=0
  - mem_address=0, mem_dataIn=0
  - mem_readEnable=0, mem_writeEnable=0
- Reset mid-operation: all of the above take effect immediately (asynchronous). The in-flight request is dropped with no write and no response. After rst_n rises, the first edge can accept a request.

## Timing
- Cycle A is the acceptance cycle.
- Load: mem_readEnable high in A+1 only; mem_memOut sampled at the end of A+2; resp_valid in A+3.
- Word store: mem_writeEnable high in A+1; resp_valid in A+2.
- Sub-word store:
  - readEnable in A+1
  - merge at the end of A+2
  - writeEnable in A+3 with merged data
  - resp_valid in A+4
- Error: resp_valid in A+1.
- Back-to-back: minimum spacing between acceptances is 3 cycles (load), 2 (word store), 4 (sub-word store), 1 (error).

## Test plan
- Memory bytes 0x10..0x13 = BB,AA,99,88. Word load at 0x10 → mem_readEnable high only in A+1; resp_rdata=0x8899AABB, resp_err=0 in A+3.
- Signed byte load at 0x13 → 0xFFFFFF88. Unsigned byte load at 0x13 → 0x00000088. Signed half load at 0x12 → 0xFFFF8899. Unsigned half load at 0x10 → 0x0000AABB.
- Byte store 0x5A to 0x11 with the same contents → readEnable in A+1; writeEnable in A+3 with mem_address=0x10, mem_dataIn=0x88995ABB; resp_valid in A+4; a following word load reads 0x88995ABB.
- Word store 0xDEADBEEF to 0x20 → no readEnable; writeEnable in A+1 with mem_dataIn=0xDEADBEEF; resp_valid in A+2.
- Each of the following gives resp_err=1 in A+1 with both enables low throughout:
  - word load at 0x12
  - half store at 0x11
  - size 11
  - word load at 0x400 (MEM_BYTES=1024)
- Word load at 0x3FC succeeds.
- Sub-word store with rst_n pulled low during CAP → enables and resp_valid drop immediately; no writeEnable ever appears and memory is unchanged. req_ready=1 after release, and a fresh load is accepted and returns correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a byte-addressed, little-endian data memory with a
// registered read port and a full-word write port; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_readEnable,
    output logic        mem_writeEnable,
    input  logic [31:0] mem_memOut
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        CAP  = 2'b10,
        WR   = 2'b11
    } lsuState_t;

    localparam logic [1:0]  SIZE_BYTE     = 2'b00;
    localparam logic [1:0]  SIZE_HALF     = 2'b01;
    localparam logic [1:0]  SIZE_WORD     = 2'b10;
    localparam logic [1:0]  SIZE_RSVD     = 2'b11;
    localparam logic [31:0] MAX_WORD_ADDR = 32'(MEM_BYTES - 4);

    // Select the addressed byte/half of a memory word and extend it to 32 bits.
    function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        logic [31:0] result;
        byteSel = word[{lane, 3'b000} +: 8];
        halfSel = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: result = {{24{sgn & byteSel[7]}}, byteSel};
            SIZE_HALF: result = {{16{sgn & halfSel[15]}}, halfSel};
            default:   result = word;
        endcase
        return result;
    endfunction

    // Overlay the low bits of the store data onto the addressed lane(s) of a word.
    function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] result;
        result = word;
        case (size)
            SIZE_BYTE: result[{lane, 3'b000} +: 8]     = wdata[7:0];
            SIZE_HALF: result[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default:   result = wdata;
        endcase
        return result;
    endfunction

    lsuState_t   stateR, stateNextS;
    logic        writeR, writeNextS;
    logic [1:0]  sizeR, sizeNextS;
    logic        signedR, signedNextS;
    logic [1:0]  laneR, laneNextS;
    logic [31:0] wdataR, wdataNextS;

    logic        readyNextS, respValidNextS, respErrNextS;
    logic [31:0] respRdataNextS, memAddrNextS, memDataNextS;
    logic        readEnNextS, writeEnNextS;
    logic        acceptS, errS;

    assign acceptS = req_valid && req_ready;
    assign errS    = (req_size == SIZE_RSVD)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   || ({req_addr[31:2], 2'b00} > MAX_WORD_ADDR);

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        stateNextS     = stateR;
        writeNextS     = writeR;
        sizeNextS      = sizeR;
        signedNextS    = signedR;
        laneNextS      = laneR;
        wdataNextS     = wdataR;
        readyNextS     = 1'b0;
        respValidNextS = 1'b0;
        respErrNextS   = 1'b0;
        respRdataNextS = 32'h0000_0000;
        memAddrNextS   = mem_address;
        memDataNextS   = mem_dataIn;
        readEnNextS    = 1'b0;
        writeEnNextS   = 1'b0;
        case (stateR)
            IDLE: begin
                if (acceptS && errS) begin
                    // Rejected requests never touch memory and answer on the next cycle.
                    readyNextS     = 1'b1;
                    respValidNextS = 1'b1;
                    respErrNextS   = 1'b1;
                end else if (acceptS) begin
                    writeNextS   = req_write;
                    sizeNextS    = req_size;
                    signedNextS  = req_signed;
                    laneNextS    = req_addr[1:0];
                    wdataNextS   = req_wdata;
                    memAddrNextS = {req_addr[31:2], 2'b00};
                    if (req_write && (req_size == SIZE_WORD)) begin
                        stateNextS   = WR;
                        writeEnNextS = 1'b1;
                        memDataNextS = req_wdata;
                    end else begin
                        stateNextS  = RD;
                        readEnNextS = 1'b1;
                    end
                end else begin
                    readyNextS = 1'b1;
                end
            end
            RD: begin
                stateNextS = CAP;
            end
            CAP: begin
                if (writeR) begin
                    stateNextS   = WR;
                    writeEnNextS = 1'b1;
                    memDataNextS = storeMerge(mem_memOut, wdataR, sizeR, laneR);
                end else begin
                    stateNextS     = IDLE;
                    readyNextS     = 1'b1;
                    respValidNextS = 1'b1;
                    respRdataNextS = loadExtend(mem_memOut, sizeR, laneR, signedR);
                end
            end
            WR: begin
                stateNextS     = IDLE;
                readyNextS     = 1'b1;
                respValidNextS = 1'b1;
            end
            default: begin
                stateNextS = IDLE;
                readyNextS = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeR          <= 1'b0;
            sizeR           <= 2'b00;
            signedR         <= 1'b0;
            laneR           <= 2'b00;
            wdataR          <= 32'h0000_0000;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= 32'h0000_0000;
            mem_address     <= 32'h0000_0000;
            mem_dataIn      <= 32'h0000_0000;
            mem_readEnable  <= 1'b0;
            mem_writeEnable <= 1'b0;
        end else begin
            writeR          <= writeNextS;
            sizeR           <= sizeNextS;
            signedR         <= signedNextS;
            laneR           <= laneNextS;
            wdataR          <= wdataNextS;
            req_ready       <= readyNextS;
            resp_valid      <= respValidNextS;
            resp_err        <= respErrNextS;
            resp_rdata      <= respRdataNextS;
            mem_address     <= memAddrNextS;
            mem_dataIn      <= memDataNextS;
            mem_readEnable  <= readEnNextS;
            mem_writeEnable <= writeEnNextS;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural registered-read memory, per-cycle
// traces of each transaction and hand-computed expected values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_address, mem_dataIn;
    logic        mem_readEnable, mem_writeEnable;
    logic [31:0] mem_memOut;

    logic [31:0] mem [0:255];

    int cmpCount = 0;
    int errCount = 0;

    // Per-cycle traces, index k = cycles after acceptance (A+k).
    logic [6:0]  reBits, weBits, rvBits, errBits, rdyBits;
    logic [31:0] rdataArr [1:6];
    logic [31:0] addrArr  [1:6];
    logic [31:0] dinArr   [1:6];

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
        .mem_memOut(mem_memOut)
    );

    always #5 clk = ~clk;

    // Memory with registered read and full-word write.
    always @(posedge clk) begin
        if (mem_readEnable) mem_memOut <= mem[mem_address[9:2]];
        if (mem_writeEnable) mem[mem_address[9:2]] <= mem_dataIn;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int rstCycle);
        int waitN = 0;
        @(negedge clk);
        while (!req_ready && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        checkVal("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        reBits = '0; weBits = '0; rvBits = '0; errBits = '0; rdyBits = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == rstCycle) begin
                rst_n = 1'b0;
                #1;
            end
            reBits[k]   = mem_readEnable;
            weBits[k]   = mem_writeEnable;
            rvBits[k]   = resp_valid;
            errBits[k]  = resp_err;
            rdyBits[k]  = req_ready;
            rdataArr[k] = resp_rdata;
            addrArr[k]  = mem_address;
            dinArr[k]   = mem_dataIn;
        end
        if (rstCycle != 0) rst_n = 1'b1;
    endtask

    task automatic checkLoad(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        checkVal({tag, "_re"}, 32'(reBits), 32'h02);
        checkVal({tag, "_we"}, 32'(weBits), 32'h00);
        checkVal({tag, "_rv"}, 32'(rvBits), 32'h08);
        checkVal({tag, "_err"}, {31'b0, errBits[3]}, 32'd0);
        checkVal({tag, "_rdata"}, rdataArr[3], exp);
        checkVal({tag, "_addr"}, addrArr[1], {addr[31:2], 2'b00});
        checkVal({tag, "_ready"}, {31'b0, rdyBits[3]}, 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
    } errVec_t;

    errVec_t errTbl [4];

    initial begin
        errTbl[0] = '{1'b0, 2'b10, 32'h0000_0012};
        errTbl[1] = '{1'b1, 2'b01, 32'h0000_0011};
        errTbl[2] = '{1'b0, 2'b11, 32'h0000_0010};
        errTbl[3] = '{1'b0, 2'b10, 32'h0000_0400};

        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_ready", {31'b0, req_ready}, 32'd1);
        checkVal("rst_resp", {29'b0, resp_valid, resp_err, mem_readEnable | mem_writeEnable}, 32'd0);
        checkVal("rst_rdata", resp_rdata, 32'h0);
        checkVal("rst_addr", mem_address, 32'h0);
        checkVal("rst_din", mem_dataIn, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word stores preload memory: bytes 0x10..0x13 = BB,AA,99,88.
        doReq(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB, 0);
        checkVal("wst10_re", 32'(reBits), 32'h00);
        checkVal("wst10_we", 32'(weBits), 32'h02);
        checkVal("wst10_rv", 32'(rvBits), 32'h04);
        checkVal("wst10_din", dinArr[1], 32'h8899_AABB);
        doReq(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h1234_5678, 0);

        doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        checkLoad("lw10", 32'h10, 32'h8899_AABB);
        doReq(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
        checkLoad("lb13", 32'h13, 32'hFFFF_FF88);
        doReq(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
        checkLoad("lbu13", 32'h13, 32'h0000_0088);
        doReq(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
        checkLoad("lh12", 32'h12, 32'hFFFF_8899);
        doReq(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
        checkLoad("lhu10", 32'h10, 32'h0000_AABB);

        // Byte store 0x5A to 0x11: read-modify-write.
        doReq(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, 0);
        checkVal("sb11_re", 32'(reBits), 32'h02);
        checkVal("sb11_we", 32'(weBits), 32'h08);
        checkVal("sb11_rv", 32'(rvBits), 32'h10);
        checkVal("sb11_addr", addrArr[3], 32'h10);
        checkVal("sb11_din", dinArr[3], 32'h8899_5ABB);
        checkVal("sb11_resp", {errBits[4], 31'b0} | rdataArr[4], 32'h0);
        doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        checkLoad("lw10_after_sb", 32'h10, 32'h8899_5ABB);

        doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 0);
        checkVal("sw20_re", 32'(reBits), 32'h00);
        checkVal("sw20_we", 32'(weBits), 32'h02);
        checkVal("sw20_rv", 32'(rvBits), 32'h04);
        checkVal("sw20_din", dinArr[1], 32'hDEAD_BEEF);
        checkVal("sw20_mem", mem[8], 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin
            doReq(errTbl[i].wr, errTbl[i].sz, 1'b0, errTbl[i].addr, 32'hFFFF_FFFF, 0);
            checkVal($sformatf("err%0d_rv", i), 32'(rvBits), 32'h02);
            checkVal($sformatf("err%0d_flag", i), {31'b0, errBits[1]}, 32'd1);
            checkVal($sformatf("err%0d_rdata", i), rdataArr[1], 32'h0);
            checkVal($sformatf("err%0d_en", i), 32'(reBits | weBits), 32'h00);
        end

        doReq(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 0);
        checkLoad("lw3fc", 32'h3FC, 32'h1234_5678);

        // Sub-word store aborted by reset while in CAP (A+2).
        doReq(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0011, 2);
        checkVal("rstmid_re", 32'(reBits), 32'h02);
        checkVal("rstmid_we", 32'(weBits), 32'h00);
        checkVal("rstmid_rv", 32'(rvBits), 32'h00);
        checkVal("rstmid_ready", {31'b0, rdyBits[2]}, 32'd1);
        checkVal("rstmid_mem", mem[8], 32'hDEAD_BEEF);
        doReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
        checkLoad("lw20_after_rst", 32'h20, 32'hDEAD_BEEF);
        doReq(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0);
        checkLoad("lbu21", 32'h21, 32'h0000_00BE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
